// File: rtl/sha256_pkg.sv
// sha256_pkg
//   Shared definitions for the SHA-256 round sequencer: FSM state encoding,
//   block/round sizing, and the message-schedule small-sigma functions.
//   Optional feature macro used by the sequencer: SHA256_HOLD_EN.
package sha256_pkg;

  localparam int NROUNDS         = 64;
  localparam int WORDS_PER_BLOCK = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  // s0 = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // s1 = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_msg_window.sv
// sha256_msg_window
//   16 x 32-bit message-schedule window. While loading, each accepted word is
//   shifted in at the top; while running rounds, the window shifts left and
//   the top slot receives the next expanded schedule word.
// Ports
//   clk    in   1   clock
//   rst_n  in   1   asynchronous active-low reset, clears the window
//   load   in   1   shift din into win[15]
//   shift  in   1   shift left, win[15] <= expansion of the current window
//   din    in   32  message word to load
//   w_t    out  32  win[0], the schedule word for the current round
module sha256_msg_window
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        shift,
  input  logic [31:0] din,
  output logic [31:0] w_t
);

  logic [31:0] win [WORDS_PER_BLOCK];
  logic [31:0] w_next;

  // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t], with win[0] = W[t]
  assign w_next = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++) win[i] <= '0;
    end else if (load || shift) begin
      for (int i = 0; i < WORDS_PER_BLOCK - 1; i++) win[i] <= win[i+1];
      win[WORDS_PER_BLOCK-1] <= load ? din : w_next;
    end
  end

  assign w_t = win[0];

endmodule

// File: rtl/sha256_round_sequencer.sv
// sha256_round_sequencer
//   Control sequencer for the SHA-256 compression core. Accepts a 512-bit
//   block as 16 words over valid/ready, then drives 64 rounds (round index,
//   schedule word, round strobe) followed by the final-add and done pulses.
//   Optional feature macro: SHA256_HOLD_EN adds the hold input, which freezes
//   the round counter and schedule window while in ROUND.
// Ports
//   clk         in   1   clock
//   rst_n       in   1   asynchronous active-low reset
//   start       in   1   request a new block (IDLE only)
//   word_valid  in   1   message word available
//   word_data   in   32  message word, W0 first
//   word_ready  out  1   accepting words (LOAD)
//   round_idx   out  7   round number to the K lookup, 0 outside ROUND
//   w_t         out  32  schedule word for the current round
//   init_load   out  1   datapath loads a..h from H
//   round_en    out  1   datapath performs one round
//   final_add   out  1   datapath adds a..h into H
//   busy        out  1   not IDLE
//   done        out  1   block finished
//   hold        in   1   (SHA256_HOLD_EN only) stall rounds
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting 16 message words
// ROUND | one compression round per cycle, rnd 0..63
// FINAL | final_add pulse
// DONE  | done pulse, then back to IDLE
module sha256_round_sequencer
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  output logic        word_ready,
  output logic [6:0]  round_idx,
  output logic [31:0] w_t,
  output logic        init_load,
  output logic        round_en,
  output logic        final_add,
  output logic        busy,
  output logic        done
`ifdef SHA256_HOLD_EN
  ,
  input  logic        hold
`endif
);

  localparam logic [6:0] RND_LAST  = 7'(NROUNDS - 1);
  localparam logic [3:0] WCNT_LAST = 4'(WORDS_PER_BLOCK - 1);

  state_t     state_q, state_d;
  logic [6:0] rnd_q, rnd_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic       win_load, win_shift;
  logic       hold_i;

`ifdef SHA256_HOLD_EN
  assign hold_i = hold;
`else
  assign hold_i = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    wcnt_d     = wcnt_q;
    word_ready = 1'b0;
    init_load  = 1'b0;
    round_en   = 1'b0;
    final_add  = 1'b0;
    done       = 1'b0;
    busy       = (state_q != IDLE);
    round_idx  = '0;
    win_load   = 1'b0;
    win_shift  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          init_load = 1'b1;
          wcnt_d    = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        word_ready = 1'b1;
        // word_ready is constant 1 here, so the handshake is just word_valid
        if (word_valid) begin
          win_load = 1'b1;
          wcnt_d   = wcnt_q + 4'd1;
          if (wcnt_q == WCNT_LAST) begin
            rnd_d   = '0;
            state_d = ROUND;
          end
        end
      end
      ROUND: begin
        round_idx = rnd_q;
        if (!hold_i) begin
          round_en  = 1'b1;
          win_shift = 1'b1;
          if (rnd_q == RND_LAST) begin
            // park the counter at 0 rather than letting it reach 64
            rnd_d   = '0;
            state_d = FINAL;
          end else begin
            rnd_d = rnd_q + 7'd1;
          end
        end
      end
      FINAL: begin
        final_add = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  sha256_msg_window u_window (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (win_load),
    .shift (win_shift),
    .din   (word_data),
    .w_t   (w_t)
  );

endmodule
